// File: rtl/baud_gen_frac_if.sv
// Control and strobe bundle between the fractional baud generator and the UART datapath.
interface baud_gen_frac_if #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
);
    logic              EN;
    logic              RESYNC;
    logic [DIV_W-1:0]  DIV_INT;
    logic [FRAC_W-1:0] DIV_FRAC;
    logic              DIV_LD;
    logic              DIV_PEND;
    logic              OVS_TICK;
    logic              MID_TICK;
    logic              BAUD_TICK;

    modport master (
        output EN, RESYNC, DIV_INT, DIV_FRAC, DIV_LD,
        input  DIV_PEND, OVS_TICK, MID_TICK, BAUD_TICK
    );

    modport slave (
        input  EN, RESYNC, DIV_INT, DIV_FRAC, DIV_LD,
        output DIV_PEND, OVS_TICK, MID_TICK, BAUD_TICK
    );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional-N oversample tick generator with derived mid-bit and bit strobes,
// shadowed runtime divisor and RX phase resync.
module baud_gen_frac #(
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned FRAC_W   = 4,
    parameter int unsigned OVS      = 16,
    parameter int unsigned DEF_INT  = 163,
    parameter int unsigned DEF_FRAC = 0
) (
    input  logic            SCLK,
    input  logic            SCLR,
    baud_gen_frac_if.slave  bus
);
    localparam int unsigned SUB_W = $clog2(OVS);
    localparam logic [DIV_W-1:0]  DEF_I = DIV_W'(DEF_INT);
    localparam logic [FRAC_W-1:0] DEF_F = FRAC_W'(DEF_FRAC);

    logic [DIV_W-1:0]  div_i, sh_i;
    logic [FRAC_W-1:0] div_f, sh_f, acc, acc_sum;
    logic              x, carry;
    logic [DIV_W:0]    cnt, div_e, last_cnt;
    logic [SUB_W-1:0]  sub;
    logic              pend, ovs_q, mid_q, baud_q;
    logic              last, fire, apply;

    always_comb begin
        div_e    = (div_i == '0) ? (DIV_W+1)'(1) : {1'b0, div_i};
        last_cnt = div_e + (DIV_W+1)'(x) - (DIV_W+1)'(1);
        last     = (cnt == last_cnt);
        fire     = bus.EN && !bus.RESYNC && last;
        {carry, acc_sum} = {1'b0, acc} + {1'b0, div_f};
        // A pending divisor lands at a tick, or at once while frozen or resyncing.
        apply    = pend && (bus.RESYNC || !bus.EN || fire);
    end

    always_ff @(posedge SCLK) begin
        if (SCLR) begin
            div_i  <= DEF_I;
            div_f  <= DEF_F;
            sh_i   <= DEF_I;
            sh_f   <= DEF_F;
            pend   <= 1'b0;
            cnt    <= '0;
            sub    <= '0;
            acc    <= '0;
            x      <= 1'b0;
            ovs_q  <= 1'b0;
            mid_q  <= 1'b0;
            baud_q <= 1'b0;
        end else begin
            ovs_q  <= fire;
            mid_q  <= fire && (sub == SUB_W'(OVS/2 - 1));
            baud_q <= fire && (sub == SUB_W'(OVS - 1));

            if (bus.RESYNC) begin
                cnt <= '0;
                sub <= '0;
                acc <= '0;
                x   <= 1'b0;
            end else if (bus.EN) begin
                if (last) begin
                    cnt <= '0;
                    sub <= sub + SUB_W'(1);
                    acc <= acc_sum;
                    x   <= carry;
                end else begin
                    cnt <= cnt + (DIV_W+1)'(1);
                end
            end

            if (bus.DIV_LD) begin
                sh_i <= bus.DIV_INT;
                sh_f <= bus.DIV_FRAC;
            end

            // A load alongside resync bypasses the shadow so it takes effect immediately.
            if (bus.RESYNC && bus.DIV_LD) begin
                div_i <= bus.DIV_INT;
                div_f <= bus.DIV_FRAC;
                pend  <= 1'b0;
            end else begin
                if (apply) begin
                    div_i <= sh_i;
                    div_f <= sh_f;
                end
                pend <= bus.DIV_LD || (pend && !apply);
            end
        end
    end

    assign bus.DIV_PEND  = pend;
    assign bus.OVS_TICK  = ovs_q;
    assign bus.MID_TICK  = mid_q;
    assign bus.BAUD_TICK = baud_q;
endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised fractional-N baud/oversample tick generator for the UART TX/RX datapaths.
- Supersedes the fixed 4-mode divider with:
  - a runtime-loadable integer + fractional divisor;
  - an oversample tick plus derived bit and mid-bit strobes;
  - phase resync for RX start-bit alignment.
- Sits between the system clock domain and the UART shift logic; all outputs are single-cycle SCLK pulses.

Parameters:
- DIV_W, 16, width of integer divisor (oversample period in SCLK cycles).
- FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W cycle).
- OVS, 16, oversample ticks per bit; power of two, >= 4.
- DEF_INT, 163, integer divisor loaded at reset.
- DEF_FRAC, 0, fractional divisor loaded at reset.

Ports:
- SCLK  in  1  system clock; all logic on rising edge.
- SCLR  in  1  synchronous, active-high reset.
- EN  in  1  count enable; low freezes all counters.
- RESYNC  in  1  1-cycle pulse; restarts bit phase.
- DIV_INT  in  DIV_W  new integer divisor.
- DIV_FRAC  in  FRAC_W  new fractional divisor.
- DIV_LD  in  1  1-cycle pulse; captures DIV_INT/DIV_FRAC into shadow.
- DIV_PEND  out  1  shadow divisor captured but not yet applied.
- OVS_TICK  out  1  oversample strobe.
- MID_TICK  out  1  mid-bit strobe.
- BAUD_TICK  out  1  bit-boundary strobe.

Behaviour:
- Reset (SCLR=1 at edge):
  - div_i=DEF_INT, div_f=DEF_FRAC, shadow=defaults.
  - cnt=0, sub=0, acc=0, x=0.
  - All outputs 0, including DIV_PEND.
  - SCLR has priority over every other input.
- Effective integer divisor: div_e = (div_i==0) ? 1 : div_i.
- Interval counter (enabled edge, EN=1, RESYNC=0):
  - If cnt == div_e+x-1: cnt<=0, OVS_TICK<=1, acc<=acc+div_f (mod 2^FRAC_W), x<=carry-out of that add.
  - Otherwise: cnt<=cnt+1, OVS_TICK<=0.
  - cnt is DIV_W+1 bits wide so div_e+x never overflows.
- Average OVS period = div_i + div_f/2^FRAC_W cycles. Each individual interval is div_e or div_e+1.
- sub counter:
  - 0..OVS-1; increments on each cycle OVS_TICK is generated; wraps OVS-1 -> 0.
  - MID_TICK<=1 in the same edge as OVS_TICK when sub==OVS/2-1.
  - BAUD_TICK<=1 in the same edge as OVS_TICK when sub==OVS-1.
  - Otherwise both 0.
- All outputs are registered; first OVS_TICK appears after div_e enabled edges following reset.
- EN=0:
  - cnt, sub, acc, x hold; all tick outputs 0 next cycle.
  - DIV_LD still captured; a pending divisor is applied immediately (next edge).
- RESYNC=1 (EN don't-care):
  - Next edge: cnt=0, sub=0, acc=0, x=0; any tick due that edge is suppressed (ticks 0).
  - Pending divisor applied at the same edge.
  - Next BAUD_TICK is OVS*div period later; MID_TICK fires at half-bit, which is the RX mid-start-bit sample.
- DIV_LD=1:
  - Shadow <= {DIV_INT,DIV_FRAC}; DIV_PEND<=1.
  - A second DIV_LD while pending overwrites the shadow, last value wins.
- Divisor apply:
  - On the edge that generates OVS_TICK (or under EN=0 / RESYNC): div_i/div_f <= shadow, DIV_PEND<=0.
  - The interval starting after that tick uses the new divisor; acc/x are not cleared.
  - DIV_LD coincident with apply: the new shadow is captured and DIV_PEND stays 1, so the new value applies at the following tick.
- RESYNC and DIV_LD in the same cycle: the shadow captures the new value and it is applied at that edge; DIV_PEND=0.
- SCLR mid-interval: all state returns to reset values the next cycle; any tick in flight is lost.

Test Plan:
- Reset, EN=1, DEF_INT=4, FRAC=0, OVS=16 -> OVS_TICK every 4 cycles (first after 4th edge); MID_TICK with 8th OVS_TICK (cycle 32); BAUD_TICK with 16th (cycle 64), repeat every 64.
- DIV_LD INT=3 FRAC=8 (FRAC_W=4) while EN=0 -> applied next edge, DIV_PEND 1 cycle. Then EN=1 -> intervals 3,3,4,3,4...; 16th OVS_TICK/BAUD_TICK at cycle 55, 32nd at cycle 111.
- INT=4 running; drop EN for 10 cycles at cnt=2 -> no ticks during gap; next OVS_TICK 2 enabled edges after EN returns; BAUD spacing otherwise unchanged.
- Pulse RESYNC 3 cycles before a scheduled BAUD_TICK -> that BAUD_TICK suppressed; MID_TICK 32 cycles after RESYNC edge, BAUD_TICK 64 after.
- Running INT=4: DIV_LD INT=8 mid-interval -> DIV_PEND high until next OVS_TICK; following intervals 8 cycles. Second DIV_LD INT=6 before that tick -> 6 applied, 8 never used.
- SCLR asserted mid-bit (sub=9) -> all outputs 0 next cycle; divisor back to DEF_INT; first OVS_TICK DEF_INT cycles after release. INT=0 load -> OVS_TICK every cycle.
